// File: rtl/clock_div_ramp_pkg.sv
// Shared definitions for the divider ramp sequencer: FSM encoding, divider code constants
// and the legal-step helper that keeps the divider's stall code off the bus.
package clock_div_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    DWELL = 2'd2
  } ramp_state_e;

  // Widest divider the helper supports; callers cast to and from their own SIZE.
  localparam int MAX_SIZE = 16;

  localparam logic [MAX_SIZE-1:0] DIV_BYPASS  = 16'd0;
  localparam logic [MAX_SIZE-1:0] DIV_ILLEGAL = 16'd1;
  localparam logic [MAX_SIZE-1:0] DIV_MIN     = 16'd2;

  // One legal move from cur toward tgt, hopping over code 1 in both directions.
  function automatic logic [MAX_SIZE-1:0] next_legal_step(
    input logic [MAX_SIZE-1:0] cur,
    input logic [MAX_SIZE-1:0] tgt
  );
    logic [MAX_SIZE-1:0] nxt;
    nxt = cur;
    if (tgt > cur) begin
      nxt = (cur == DIV_BYPASS) ? DIV_MIN : cur + 16'd1;
    end else if (tgt < cur) begin
      nxt = (cur == DIV_MIN) ? DIV_BYPASS : cur - 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/clock_div_ramp_dwell_timer.sv
// Load/decrement down counter with a zero flag; load wins over decrement, stops at zero.
// Latency: load visible next cycle. No backpressure.
module clock_div_ramp_dwell_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clock_div_ramp.sv
// Walks the divider code N one legal step at a time toward a requested target, dwelling after each step.
// Latency: k*(1+DWELL_CYCLES)+1 cycles accept-to-done. Backpressure: req_ready low while ramping; no queueing.
module clock_div_ramp
  import clock_div_ramp_pkg::*;
#(
  parameter int SIZE         = 3,
  parameter int DWELL_CYCLES = 24,
  parameter int RESET_N      = 2
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic [SIZE-1:0] req_N,
  input  logic            req_valid,
  output logic            req_ready,
  output logic [SIZE-1:0] N,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [SIZE-1:0]  N_RESET    = SIZE'(RESET_N);

  ramp_state_e     state_q, state_d;
  logic [SIZE-1:0] n_q, n_d;
  logic [SIZE-1:0] target_q, target_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  logic [SIZE-1:0] req_norm;
  logic [SIZE-1:0] n_step;
  logic            tmr_load;
  logic            tmr_dec;
  logic            tmr_zero;

  // Code 1 would stall the divider, so it is promoted to the smallest real ratio.
  assign req_norm = (req_N == SIZE'(DIV_ILLEGAL)) ? SIZE'(DIV_MIN) : req_N;
  assign n_step   = SIZE'(next_legal_step(MAX_SIZE'(n_q), MAX_SIZE'(target_q)));

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    target_d = target_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          if (req_norm == n_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_norm;
            state_d  = STEP;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
          end
        end
      end

      STEP: begin
        n_d      = n_step;
        tmr_load = 1'b1;
        state_d  = DWELL;
      end

      DWELL: begin
        if (tmr_zero) begin
          if (n_q == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            state_d = STEP;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      n_q      <= N_RESET;
      target_q <= N_RESET;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  clock_div_ramp_dwell_timer #(
    .W (CNT_W)
  ) u_dwell_timer (
    .clk      (clk),
    .resetb   (resetb),
    .load     (tmr_load),
    .load_val (DWELL_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign N         = n_q;
  assign busy      = busy_q;
  assign req_ready = ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_clock_div_ramp.sv
// Directed bench for clock_div_ramp: table of ramp requests plus reset and ignored-request sequences.
module tb_clock_div_ramp;

  localparam int DWELL = 24;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [2:0] req_N = 3'd0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] N;
  logic       busy;
  logic       done;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  req;
    int          k;
    logic [23:0] seq;
    logic [2:0]  fin;
  } vec_t;

  vec_t vecs [7];

  clock_div_ramp #(
    .SIZE         (3),
    .DWELL_CYCLES (DWELL),
    .RESET_N      (2)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .req_N     (req_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .N         (N),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_req(input logic [2:0] r, input int k, input logic [23:0] seq,
                         input logic [2:0] fin, input bit poke);
    int         acc;
    int         last_chg;
    int         steps;
    int         busy_bad;
    int         one_seen;
    int         lat;
    int         extra_done;
    bit         got;
    logic [2:0] prev;
    steps = 0; busy_bad = 0; one_seen = 0; lat = 0; got = 1'b0; last_chg = 0; extra_done = 0;

    @(posedge clk); #1;
    chk("ready_before_req", int'(req_ready), 1);
    prev      = N;
    req_N     = r;
    req_valid = 1'b1;
    @(posedge clk); #1;
    acc       = cyc;
    req_valid = 1'b0;
    req_N     = ~r;

    for (int i = 0; i < 400; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (poke && i == 30) begin
        chk("ready_low_mid_ramp", int'(req_ready), 0);
        req_N     = 3'd3;
        req_valid = 1'b1;
      end
      if (poke && i == 31) req_valid = 1'b0;
      if (N == 3'd1) one_seen++;
      if (N != prev) begin
        if (steps < 8) chk("step_value", int'(N), int'(seq[3*steps +: 3]));
        if (steps > 0) chk("step_spacing", cyc - last_chg, DWELL + 1);
        last_chg = cyc;
        steps++;
        prev = N;
      end
      if (done) begin
        got = 1'b1;
        lat = cyc - acc + 1;
        break;
      end
      if (busy !== (k > 0) || req_ready !== (k == 0)) busy_bad++;
    end

    chk("done_seen", int'(got), 1);
    if (got) begin
      chk("latency", lat, k * (DWELL + 1) + 1);
      chk("busy_at_done", int'(busy), 0);
      chk("ready_at_done", int'(req_ready), 1);
    end
    chk("final_N", int'(N), int'(fin));
    chk("step_count", steps, k);
    chk("busy_ready_during_ramp", busy_bad, 0);
    chk("code1_never_seen", one_seen, 0);

    @(posedge clk); #1;
    chk("done_single_pulse", int'(done), 0);
    if (poke) begin
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done) extra_done++;
      end
      chk("no_extra_done", extra_done, 0);
      chk("N_after_ignored_req", int'(N), int'(fin));
    end
  endtask

  initial begin
    vecs[0] = '{req: 3'd7, k: 5, seq: 24'({3'd7, 3'd6, 3'd5, 3'd4, 3'd3}), fin: 3'd7};
    vecs[1] = '{req: 3'd4, k: 3, seq: 24'({3'd4, 3'd5, 3'd6}),             fin: 3'd4};
    vecs[2] = '{req: 3'd0, k: 3, seq: 24'({3'd0, 3'd2, 3'd3}),             fin: 3'd0};
    vecs[3] = '{req: 3'd5, k: 4, seq: 24'({3'd5, 3'd4, 3'd3, 3'd2}),       fin: 3'd5};
    vecs[4] = '{req: 3'd1, k: 3, seq: 24'({3'd2, 3'd3, 3'd4}),             fin: 3'd2};
    vecs[5] = '{req: 3'd2, k: 0, seq: 24'd0,                               fin: 3'd2};
    vecs[6] = '{req: 3'd3, k: 1, seq: 24'({3'd3}),                         fin: 3'd3};

    #12;
    chk("in_reset_N", int'(N), 2);
    chk("in_reset_ready", int'(req_ready), 1);
    resetb = 1'b1;
    @(posedge clk); #1;
    chk("reset_N", int'(N), 2);
    chk("reset_ready", int'(req_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);

    foreach (vecs[i]) begin
      run_req(vecs[i].req, vecs[i].k, vecs[i].seq, vecs[i].fin, 1'b0);
    end

    // From N=3: ramp to 7 with a poke while not ready that must be dropped.
    run_req(3'd7, 4, 24'({3'd7, 3'd6, 3'd5, 3'd4}), 3'd7, 1'b1);

    // Reset during the second dwell of a 7 -> 0 ramp.
    @(posedge clk); #1;
    req_N     = 3'd0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("mid_dwell_N", int'(N), 5);
    chk("mid_dwell_busy", int'(busy), 1);
    #3 resetb = 1'b0;
    #1;
    chk("async_reset_N", int'(N), 2);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_ready", int'(req_ready), 1);
    #2 resetb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_N_held", int'(N), 2);
    chk("post_reset_no_done", int'(done), 0);
    run_req(3'd3, 1, 24'({3'd3}), 3'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
